// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit with an internal scoreboard of in-flight destinations and a stall counter.
// Build option: define HAZARD_FORWARDING_EN to stall only on load-use and forward all other matches.
module hazard_scoreboard #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2,
    parameter int FWD_W  = $clog2(DEPTH + 1),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic              two_src,
    input  logic              hazard_ignore,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic              stall_clr,
    output logic              hazard,
    output logic [FWD_W-1:0]  fwd_sel1,
    output logic [FWD_W-1:0]  fwd_sel2,
    output logic [CNT_W-1:0]  stall_count
);

    // Only the EXE entry ever needs its load flag, so older entries do not carry one.
    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  wb_en_r;
    logic [ADDR_W-1:0] dest_r [DEPTH];
    logic              mem0_r;
    logic [CNT_W-1:0]  stall_count_r;

    logic [DEPTH-1:0]  match1_s;
    logic [DEPTH-1:0]  match2_s;
    logic              use1_s;
    logic              use2_s;
    logic              load_use_s;
    logic              hazard_s;
    logic              bubble_s;
    logic [FWD_W-1:0]  sel1_s;
    logic [FWD_W-1:0]  sel2_s;

    // Source/scoreboard comparison, hazard decision and forward selection.
    always_comb begin
        use1_s   = id_valid & ~hazard_ignore;
        use2_s   = use1_s & two_src;
        match1_s = {DEPTH{1'b0}};
        match2_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            match1_s[k] = use1_s & valid_r[k] & wb_en_r[k] & (dest_r[k] == src1);
            match2_s[k] = use2_s & valid_r[k] & wb_en_r[k] & (dest_r[k] == src2);
        end
        load_use_s = (match1_s[0] | match2_s[0]) & mem0_r;
`ifdef HAZARD_FORWARDING_EN
        hazard_s = load_use_s;
        sel1_s   = {FWD_W{1'b0}};
        sel2_s   = {FWD_W{1'b0}};
        // Scan oldest to youngest so the youngest match overwrites.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            sel1_s = match1_s[k] ? FWD_W'(k + 1) : sel1_s;
            sel2_s = match2_s[k] ? FWD_W'(k + 1) : sel2_s;
        end
`else
        // A load-use match is a subset of "any match"; OR-ing it in changes nothing.
        hazard_s = (|match1_s) | (|match2_s) | load_use_s;
        sel1_s   = {FWD_W{1'b0}};
        sel2_s   = {FWD_W{1'b0}};
`endif
        bubble_s = hazard_s | flush | ~id_valid;
    end

    assign hazard      = hazard_s;
    assign fwd_sel1    = sel1_s;
    assign fwd_sel2    = sel2_s;
    assign stall_count = stall_count_r;

    // Scoreboard shift: one stage per unfrozen cycle, bubble when ID does not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
            wb_en_r <= {DEPTH{1'b0}};
            mem0_r  <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                dest_r[k] <= {ADDR_W{1'b0}};
            end
        end else if (!freeze) begin
            for (int k = 1; k < DEPTH; k++) begin
                valid_r[k] <= valid_r[k-1];
                wb_en_r[k] <= wb_en_r[k-1];
                dest_r[k]  <= dest_r[k-1];
            end
            valid_r[0] <= ~bubble_s;
            wb_en_r[0] <= ~bubble_s & id_wb_en;
            dest_r[0]  <= bubble_s ? {ADDR_W{1'b0}} : id_dest;
            mem0_r     <= ~bubble_s & id_mem_read;
        end
    end

    // Saturating stall-cycle counter; a clear always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_clr) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (hazard_s & ~freeze & ~(&stall_count_r)) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic vs a queue model.
module tb_hazard_scoreboard;

    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 2;
    localparam int FWD_W   = $clog2(DEPTH + 1);
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              freeze, flush, id_valid, two_src, hazard_ignore;
    logic              id_wb_en, id_mem_read, stall_clr;
    logic [ADDR_W-1:0] src1, src2, id_dest;
    logic              hazard;
    logic [FWD_W-1:0]  fwd_sel1, fwd_sel2;
    logic [CNT_W-1:0]  stall_count;

    hazard_scoreboard #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .src1(src1), .src2(src2), .two_src(two_src), .hazard_ignore(hazard_ignore),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .stall_clr(stall_clr), .hazard(hazard), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference: q[age] is the instruction that left ID age+1 edges ago.
    typedef struct {bit v; int d; bit w; bit m;} instr_t;
    instr_t q[$];
    int     m_cnt;
    int     n_checks, n_fail;
    bit     obs_h, exp_h;
    int     obs_f1, obs_f2;
    int     s, c0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < DEPTH; k++) q.push_back('{1'b0, 0, 1'b0, 1'b0});
        m_cnt = 0;
    endtask

    function automatic void model_eval(output bit h, output int f1, output int f2);
        int y1, y2;
        bit u1, u2;
        y1 = -1;
        y2 = -1;
        u1 = id_valid && !hazard_ignore;
        u2 = u1 && two_src;
        for (int k = 0; k < DEPTH; k++) begin
            if (q[k].v && q[k].w) begin
                if (u1 && y1 < 0 && q[k].d == int'(src1)) y1 = k;
                if (u2 && y2 < 0 && q[k].d == int'(src2)) y2 = k;
            end
        end
        if (FWD) begin
            h  = (y1 == 0 || y2 == 0) && q[0].m;
            f1 = y1 + 1;
            f2 = y2 + 1;
        end else begin
            h  = (y1 >= 0) || (y2 >= 0);
            f1 = 0;
            f2 = 0;
        end
    endfunction

    task automatic tick();
        bit     h;
        int     f1, f2;
        instr_t e;
        @(negedge clk);
        model_eval(h, f1, f2);
        exp_h  = h;
        obs_h  = hazard;
        obs_f1 = int'(fwd_sel1);
        obs_f2 = int'(fwd_sel2);
        check("hazard", hazard, h);
        check("fwd_sel1", fwd_sel1, f1);
        check("fwd_sel2", fwd_sel2, f2);
        check("stall_count", stall_count, m_cnt);
        @(posedge clk);
        if (stall_clr) m_cnt = 0;
        else if (h && !freeze && m_cnt < CNT_MAX) m_cnt++;
        if (!freeze) begin
            e = '{1'b0, 0, 1'b0, 1'b0};
            if (!(h || flush || !id_valid)) e = '{1'b1, int'(id_dest), id_wb_en, id_mem_read};
            q.push_front(e);
            void'(q.pop_back());
        end
        #1;
    endtask

    task automatic set_in(input bit v, input int s1, input int s2, input bit two,
                          input int d, input bit wb, input bit mr);
        id_valid      = v;
        src1          = ADDR_W'(s1);
        src2          = ADDR_W'(s2);
        two_src       = two;
        hazard_ignore = 1'b0;
        id_dest       = ADDR_W'(d);
        id_wb_en      = wb;
        id_mem_read   = mr;
    endtask

    // Hold the ID instruction until the model says it advances; count observed stall cycles.
    task automatic run(output int stalls);
        int i;
        i = 0;
        stalls = 0;
        do begin
            tick();
            if (obs_h) stalls++;
            i++;
        end while (exp_h && i < 20);
        check("run_done", exp_h, 0);
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        freeze    = 1'b0;
        flush     = 1'b0;
        stall_clr = 1'b0;
        set_in(1'b1, 3, 3, 1'b1, 3, 1'b1, 1'b1);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check("rst_hazard", hazard, 0);
            check("rst_fwd1", fwd_sel1, 0);
            check("rst_fwd2", fwd_sel2, 0);
            check("rst_count", stall_count, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // ADD r3 then SUB reading r3
        set_in(1'b1, 0, 0, 1'b0, 3, 1'b1, 1'b0); run(s);
        set_in(1'b1, 3, 0, 1'b0, 8, 1'b1, 1'b0); run(s);
        check("add_sub_stalls", s, FWD ? 0 : 2);
        check("add_sub_fwd1", obs_f1, FWD ? 1 : 0);
        check("add_sub_count", stall_count, FWD ? 0 : 2);
        idle(3);

        // one independent instruction in between
        set_in(1'b1, 0, 0, 1'b0, 3, 1'b1, 1'b0); run(s);
        set_in(1'b1, 1, 2, 1'b1, 9, 1'b1, 1'b0); run(s);
        set_in(1'b1, 3, 0, 1'b0, 10, 1'b1, 1'b0); run(s);
        check("gap_stalls", s, FWD ? 0 : 1);
        check("gap_fwd1", obs_f1, FWD ? 2 : 0);
        idle(3);

        // load-use on src2
        set_in(1'b1, 0, 0, 1'b0, 5, 1'b1, 1'b1); run(s);
        set_in(1'b1, 1, 5, 1'b1, 6, 1'b1, 1'b0); run(s);
        check("ldr_stalls", s, FWD ? 1 : 2);
        check("ldr_fwd2", obs_f2, FWD ? 2 : 0);
        idle(3);
        set_in(1'b1, 0, 0, 1'b0, 5, 1'b1, 1'b1); run(s);
        set_in(1'b1, 1, 5, 1'b0, 6, 1'b1, 1'b0); run(s);
        check("ldr_one_src", s, 0);
        idle(3);

        // freeze held across an active stall
        set_in(1'b1, 0, 0, 1'b0, 3, 1'b1, 1'b1); run(s);
        set_in(1'b1, 3, 0, 1'b0, 4, 1'b1, 1'b0);
        c0 = int'(stall_count);
        freeze = 1'b1;
        repeat (3) begin
            tick();
            check("frz_hazard", obs_h, 1);
            check("frz_count", stall_count, c0);
        end
        freeze = 1'b0;
        run(s);
        check("frz_release", s, FWD ? 1 : 2);
        idle(3);

        // flushed writer of r7 leaves no trace
        flush = 1'b1;
        set_in(1'b1, 0, 0, 1'b0, 7, 1'b1, 1'b1); run(s);
        flush = 1'b0;
        set_in(1'b1, 7, 0, 1'b0, 8, 1'b1, 1'b0); run(s);
        check("flush_stalls", s, 0);
        check("flush_fwd1", obs_f1, 0);
        idle(3);

        // chain of dependent loads drives the counter into saturation
        for (int i = 0; i < 70; i++) begin
            set_in(1'b1, 3, 0, 1'b0, 3, 1'b1, 1'b1);
            run(s);
        end
        check("sat_count", stall_count, CNT_MAX);
        set_in(1'b1, 3, 0, 1'b0, 3, 1'b1, 1'b1);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        check("clr_hazard", obs_h, 1);
        check("clr_count", stall_count, 0);
        run(s);
        idle(3);

        // asynchronous reset in the middle of a stall
        set_in(1'b1, 0, 0, 1'b0, 3, 1'b1, 1'b1); run(s);
        set_in(1'b1, 3, 0, 1'b0, 4, 1'b1, 1'b0);
        #2;
        check("pre_rst_hazard", hazard, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_hazard", hazard, 0);
        check("async_rst_fwd1", fwd_sel1, 0);
        check("async_rst_count", stall_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // random traffic over a small register window to provoke matches
        for (int i = 0; i < 400; i++) begin
            freeze        = ($urandom_range(9) == 0);
            flush         = ($urandom_range(9) == 0);
            stall_clr     = ($urandom_range(29) == 0);
            id_valid      = ($urandom_range(6) != 0);
            hazard_ignore = ($urandom_range(9) == 0);
            two_src       = $urandom_range(1);
            src1          = ADDR_W'($urandom_range(3));
            src2          = ADDR_W'($urandom_range(3));
            id_dest       = ADDR_W'($urandom_range(3));
            id_wb_en      = ($urandom_range(4) != 0);
            id_mem_read   = $urandom_range(1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
